control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multicycle main controller that consumes `codop` from the datapath and drives every datapath control input.
- Moore FSM: fetch, decode, then an opcode-specific sequence of 1–3 further states.
- Latches the opcode in DECODE, so later states do not depend on the IR, which reloads every cycle.
- Also provides halt and illegal-opcode status plus an instruction-retired pulse.

Parameters:
- OPC_W, 6 (`OPCODE_WIDTH`): opcode width.
- ALU_W, 4 (`ALU_SEL_SIZE`): ALU operation select width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- codop  in  OPC_W  opcode, equal to ir[5:0]
- pcWrSel  out  2  PC source: 0 = ALU result, 1 = D register, 2 = jump target
- pcCtrl  out  1  unconditional PC write
- memAdrSel  out  1  memory address: 0 = PC, 1 = D register
- memWrCtl  out  1  memory write enable
- aluOp  out  ALU_W  ALU operation
- aluASel  out  1  ALU A operand: 0 = PC, 1 = A register
- aluBSel  out  2  ALU B operand: 0 = B register, 1 = constant 4, 2 = sign-extended imm16
- regWCtl  out  1  register file write enable
- regDataSel  out  1  register write data: 0 = DM, 1 = D register
- regWSel  out  2  write address: 0 = ir[21:17], 1 = ir[26:22], 2 = r15
- halted  out  1  FSM is in HALT
- illegal  out  1  sticky flag: halt was caused by an undefined opcode
- instret  out  1  one-cycle pulse on the last state of each instruction
- cycle_cnt  out  32  performance counter (see Optional Feature)
- instret_cnt  out  32  performance counter (see Optional Feature)

Behaviour:
- Opcodes:
  - ADD 0x01, SUB 0x02, AND 0x03, OR 0x04, SLT 0x05
  - ADDI 0x08, LW 0x10, SW 0x11, BEQ 0x18
  - J 0x20, JAL 0x21, HALT 0x3F
  - Any other value is illegal.
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, SLT 4, EQ 5 (result 1 if equal, else 0), PASSA 6.
- Default outputs in every state: all signals 0. Each state lists only what it sets.
- Reset:
  - rst_n low at a clock edge: state ← FETCH, op_q ← 0, illegal ← 0, counters ← 0.
  - While rst_n is low, outputs are forced to their defaults, so no PC, memory or register write can occur.
  - Reset mid-instruction abandons that instruction; FETCH runs on the first cycle after rst_n rises.
- States and transitions:
  - FETCH: aluASel=0, aluBSel=1, aluOp=ADD, pcWrSel=0, pcCtrl=1 (PC ← PC+4). Next: DECODE.
  - DECODE: op_q ← codop; aluASel=0, aluBSel=2, aluOp=ADD (D ← branch target). Next depends on codop:
    - R-type → EXEC_R; ADDI → EXEC_I; LW/SW → MEM_ADDR; BEQ → BRANCH; J → JUMP; JAL → JAL_LINK
    - HALT → HALT; illegal → HALT with illegal ← 1
  - EXEC_R: aluASel=1, aluBSel=0, aluOp from op_q. Next: ALU_WB.
  - EXEC_I: aluASel=1, aluBSel=2, aluOp=ADD. Next: ALU_WB.
  - ALU_WB: regWCtl=1, regDataSel=1, regWSel=0 for R-type, 1 for ADDI; instret=1. Next: FETCH.
  - MEM_ADDR: aluASel=1, aluBSel=2, aluOp=ADD. Next: MEM_RD for LW, MEM_WR for SW.
  - MEM_RD: memAdrSel=1. Next: MEM_WB.
  - MEM_WB: regWCtl=1, regDataSel=0, regWSel=1; instret=1. Next: FETCH.
  - MEM_WR: memAdrSel=1, memWrCtl=1; instret=1. Next: FETCH.
  - BRANCH: aluASel=1, aluBSel=0, aluOp=EQ, pcWrSel=1, pcCtrl=0 (datapath writes PC when the ALU result equals 1); instret=1. Next: FETCH.
  - JUMP: pcWrSel=2, pcCtrl=1; instret=1. Next: FETCH.
  - JAL_LINK: aluASel=0, aluOp=PASSA (D ← PC+4), pcWrSel=2, pcCtrl=1. Next: JAL_WB.
  - JAL_WB: regWCtl=1, regDataSel=1, regWSel=2; instret=1. Next: FETCH.
  - HALT: halted=1, all enables 0. Exit only through reset.
- Latency in cycles: R-type and ADDI 4, LW 5, SW 4, BEQ 3, J 3, JAL 4.
- Exactly one instret pulse per retired instruction; the HALT opcode does not retire.
- codop is sampled only in DECODE; it is ignored in every other state.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments on every non-reset cycle where halted=0.
  - instret_cnt increments on each instret pulse.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- types.sv holds:
  - opcode defines (OPC_ADD … OPC_HALT)
  - ALU op defines (ALU_ADD … ALU_PASSA)
  - state enum typedef ctrl_state_t
  - mux select constants for pcWrSel, aluBSel and regWSel
- One natural sub-module: ctrl_output_decoder, a purely combinational map from (state, op_q) to control outputs.
- control_unit keeps the next-state logic, op_q, illegal and the counters.

Test Plan:
- Reset held 3 cycles, then ADD (0x01) → state sequence FETCH, DECODE, EXEC_R, ALU_WB; ALU_WB shows regWCtl=1, regDataSel=1, regWSel=0; instret high exactly in cycle 4; pcCtrl=1 only in FETCH.
- LW (0x10) then SW (0x11) → LW takes 5 cycles with memAdrSel=1 in MEM_RD and regWSel=1 in MEM_WB; SW takes 4 cycles with memWrCtl=1 only in MEM_WR.
- BEQ (0x18), with codop changed to 0x3F in the BRANCH cycle → aluOp=5, pcWrSel=1, pcCtrl=0; next state is FETCH, which shows op_q is used rather than the live codop.
- JAL (0x21) → JAL_LINK drives aluOp=6, pcWrSel=2, pcCtrl=1; JAL_WB drives regWSel=2, regWCtl=1.
- Opcode 0x3E → HALT with halted=1 and illegal=1, all enables 0 for 20 cycles; rst_n pulsed low → FETCH with illegal=0.
- rst_n low during MEM_WR → memWrCtl=0 in that cycle, next state FETCH; with CTRL_PERF_CNT_EN defined, cycle_cnt=0 and instret_cnt=0 after reset.

Source files
------------

// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcodes, ALU codes, FSM states and mux selects shared by the multicycle controller.
package control_unit_pkg;

    localparam int OPC_W = 6;
    localparam int ALU_W = 4;

    localparam logic [OPC_W-1:0] OPC_ADD  = 6'h01;
    localparam logic [OPC_W-1:0] OPC_SUB  = 6'h02;
    localparam logic [OPC_W-1:0] OPC_AND  = 6'h03;
    localparam logic [OPC_W-1:0] OPC_OR   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_SLT  = 6'h05;
    localparam logic [OPC_W-1:0] OPC_ADDI = 6'h08;
    localparam logic [OPC_W-1:0] OPC_LW   = 6'h10;
    localparam logic [OPC_W-1:0] OPC_SW   = 6'h11;
    localparam logic [OPC_W-1:0] OPC_BEQ  = 6'h18;
    localparam logic [OPC_W-1:0] OPC_J    = 6'h20;
    localparam logic [OPC_W-1:0] OPC_JAL  = 6'h21;
    localparam logic [OPC_W-1:0] OPC_HALT = 6'h3F;

    localparam logic [ALU_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLT   = 4'd4;
    localparam logic [ALU_W-1:0] ALU_EQ    = 4'd5;
    localparam logic [ALU_W-1:0] ALU_PASSA = 4'd6;

    localparam logic [1:0] PC_ALU = 2'd0;
    localparam logic [1:0] PC_D   = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    localparam logic [1:0] B_REG  = 2'd0;
    localparam logic [1:0] B_FOUR = 2'd1;
    localparam logic [1:0] B_IMM  = 2'd2;

    localparam logic [1:0] W_RD  = 2'd0;
    localparam logic [1:0] W_RT  = 2'd1;
    localparam logic [1:0] W_R15 = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL_LINK, S_JAL_WB, S_HALT
    } ctrl_state_t;

    typedef struct packed {
        logic [1:0]       pc_wr_sel;
        logic             pc_ctrl;
        logic             mem_adr_sel;
        logic             mem_wr_ctl;
        logic [ALU_W-1:0] alu_op;
        logic             alu_a_sel;
        logic [1:0]       alu_b_sel;
        logic             reg_w_ctl;
        logic             reg_data_sel;
        logic [1:0]       reg_w_sel;
        logic             halted;
        logic             instret;
    } ctrl_t;

    // R-type opcodes 1..5 map onto ALU codes 0..4 in the same order
    function automatic logic [ALU_W-1:0] rtype_alu(input logic [OPC_W-1:0] op);
        return ALU_W'(op - OPC_ADD);
    endfunction

    function automatic ctrl_state_t decode_target(input logic [OPC_W-1:0] op);
        case (op)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SLT: return S_EXEC_R;
            OPC_ADDI:       return S_EXEC_I;
            OPC_LW, OPC_SW: return S_MEM_ADDR;
            OPC_BEQ:        return S_BRANCH;
            OPC_J:          return S_JUMP;
            OPC_JAL:        return S_JAL_LINK;
            default:        return S_HALT;
        endcase
    endfunction

    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        return op == OPC_HALT || decode_target(op) != S_HALT;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: opcode in, datapath controls and status out, between controller (master) and datapath (slave).
interface control_unit_if;
    import control_unit_pkg::*;
    logic [OPC_W-1:0] codop;
    logic [1:0]       pcWrSel;
    logic             pcCtrl;
    logic             memAdrSel;
    logic             memWrCtl;
    logic [ALU_W-1:0] aluOp;
    logic             aluASel;
    logic [1:0]       aluBSel;
    logic             regWCtl;
    logic             regDataSel;
    logic [1:0]       regWSel;
    logic             halted;
    logic             illegal;
    logic             instret;
    logic [31:0]      cycle_cnt;
    logic [31:0]      instret_cnt;
    modport master (input codop, output pcWrSel, pcCtrl, memAdrSel, memWrCtl, aluOp, aluASel,
                    aluBSel, regWCtl, regDataSel, regWSel, halted, illegal, instret, cycle_cnt, instret_cnt);
    modport slave (output codop, input pcWrSel, pcCtrl, memAdrSel, memWrCtl, aluOp, aluASel,
                   aluBSel, regWCtl, regDataSel, regWSel, halted, illegal, instret, cycle_cnt, instret_cnt);
endinterface

// File: rtl/control_unit_decoder.sv
// ctrl_output_decoder: Moore output map from (state, latched opcode); en low forces every output to 0.
module ctrl_output_decoder
    import control_unit_pkg::*;
(
    input  ctrl_state_t      state,
    input  logic [OPC_W-1:0] op_q,
    input  logic             en,
    output ctrl_t            ctl
);
    always_comb begin
        ctl = '0;
        if (en) begin
            case (state)
                S_FETCH:  begin ctl.alu_b_sel = B_FOUR; ctl.pc_ctrl = 1'b1; end
                S_DECODE: ctl.alu_b_sel = B_IMM;
                S_EXEC_R: begin ctl.alu_a_sel = 1'b1; ctl.alu_op = rtype_alu(op_q); end
                S_EXEC_I, S_MEM_ADDR: begin ctl.alu_a_sel = 1'b1; ctl.alu_b_sel = B_IMM; end
                S_ALU_WB: begin
                    ctl.reg_w_ctl = 1'b1;
                    ctl.reg_data_sel = 1'b1;
                    ctl.reg_w_sel = op_q == OPC_ADDI ? W_RT : W_RD;
                    ctl.instret = 1'b1;
                end
                S_MEM_RD: ctl.mem_adr_sel = 1'b1;
                S_MEM_WB: begin ctl.reg_w_ctl = 1'b1; ctl.reg_w_sel = W_RT; ctl.instret = 1'b1; end
                S_MEM_WR: begin ctl.mem_adr_sel = 1'b1; ctl.mem_wr_ctl = 1'b1; ctl.instret = 1'b1; end
                S_BRANCH: begin
                    ctl.alu_a_sel = 1'b1;
                    ctl.alu_op = ALU_EQ;
                    ctl.pc_wr_sel = PC_D;
                    ctl.instret = 1'b1;
                end
                S_JUMP: begin ctl.pc_wr_sel = PC_JMP; ctl.pc_ctrl = 1'b1; ctl.instret = 1'b1; end
                S_JAL_LINK: begin ctl.alu_op = ALU_PASSA; ctl.pc_wr_sel = PC_JMP; ctl.pc_ctrl = 1'b1; end
                S_JAL_WB: begin
                    ctl.reg_w_ctl = 1'b1;
                    ctl.reg_data_sel = 1'b1;
                    ctl.reg_w_sel = W_R15;
                    ctl.instret = 1'b1;
                end
                S_HALT: ctl.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle Moore controller; define CTRL_PERF_CNT_EN to build the cycle/instret counters.
module control_unit
    import control_unit_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    control_unit_if.master bus
);
    ctrl_state_t      state_q, state_d;
    logic [OPC_W-1:0] op_q;
    logic             illegal_q;
    ctrl_t            ctl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= bus.codop;
            if (state_q == S_DECODE && !is_legal(bus.codop)) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:            state_d = S_DECODE;
            S_DECODE:           state_d = decode_target(bus.codop);
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR:         state_d = op_q == OPC_LW ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:           state_d = S_MEM_WB;
            S_JAL_LINK:         state_d = S_JAL_WB;
            S_HALT:             state_d = S_HALT;
            default:            state_d = S_FETCH;
        endcase
    end

    ctrl_output_decoder u_dec (.state(state_q), .op_q(op_q), .en(rst_n), .ctl(ctl));

    assign bus.pcWrSel    = ctl.pc_wr_sel;
    assign bus.pcCtrl     = ctl.pc_ctrl;
    assign bus.memAdrSel  = ctl.mem_adr_sel;
    assign bus.memWrCtl   = ctl.mem_wr_ctl;
    assign bus.aluOp      = ctl.alu_op;
    assign bus.aluASel    = ctl.alu_a_sel;
    assign bus.aluBSel    = ctl.alu_b_sel;
    assign bus.regWCtl    = ctl.reg_w_ctl;
    assign bus.regDataSel = ctl.reg_data_sel;
    assign bus.regWSel    = ctl.reg_w_sel;
    assign bus.halted     = ctl.halted;
    assign bus.instret    = ctl.instret;
    assign bus.illegal    = rst_n & illegal_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cyc_q, ret_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_HALT) cyc_q <= cyc_q + 32'd1;
            if (ctl.instret) ret_q <= ret_q + 32'd1;
        end
    end
    assign bus.cycle_cnt   = cyc_q;
    assign bus.instret_cnt = ret_q;
`else
    assign bus.cycle_cnt   = '0;
    assign bus.instret_cnt = '0;
`endif
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: per-cycle scoreboard of expected control vectors for every opcode class, halt and reset.
module tb_control_unit;
    import control_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_unit_if bus ();
    control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0, errors = 0, n_ret = 0, n_cyc = 0;
    logic [18:0] exp_q[$];
    string tag_q[$];
    localparam logic [5:0] G = 6'h3F;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {pcWrSel, pcCtrl, memAdrSel, memWrCtl, aluOp, aluASel, aluBSel, regWCtl, regDataSel, regWSel, halted, illegal, instret}
    function automatic logic [18:0] ev(input int pcs, pcc, mas, mwc, alu, as, bs, rw, rds, rws, h, il, ir);
        return {2'(pcs), 1'(pcc), 1'(mas), 1'(mwc), 4'(alu), 1'(as), 2'(bs), 1'(rw), 1'(rds), 2'(rws), 1'(h), 1'(il), 1'(ir)};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.pcWrSel, bus.pcCtrl, bus.memAdrSel, bus.memWrCtl, bus.aluOp, bus.aluASel, bus.aluBSel,
                bus.regWCtl, bus.regDataSel, bus.regWSel, bus.halted, bus.illegal, bus.instret};
    endfunction

    localparam logic [18:0] E_ZERO    = 19'd0;
    localparam logic [18:0] E_FETCH   = ev(0,1,0,0,0,0,1,0,0,0,0,0,0);
    localparam logic [18:0] E_DECODE  = ev(0,0,0,0,0,0,2,0,0,0,0,0,0);
    localparam logic [18:0] E_ADDR    = ev(0,0,0,0,0,1,2,0,0,0,0,0,0);
    localparam logic [18:0] E_WB_R    = ev(0,0,0,0,0,0,0,1,1,0,0,0,1);
    localparam logic [18:0] E_WB_I    = ev(0,0,0,0,0,0,0,1,1,1,0,0,1);
    localparam logic [18:0] E_MEM_RD  = ev(0,0,1,0,0,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_MEM_WB  = ev(0,0,0,0,0,0,0,1,0,1,0,0,1);
    localparam logic [18:0] E_MEM_WR  = ev(0,0,1,1,0,0,0,0,0,0,0,0,1);
    localparam logic [18:0] E_BRANCH  = ev(1,0,0,0,5,1,0,0,0,0,0,0,1);
    localparam logic [18:0] E_JUMP    = ev(2,1,0,0,0,0,0,0,0,0,0,0,1);
    localparam logic [18:0] E_JAL_LNK = ev(2,1,0,0,6,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_JAL_WB  = ev(0,0,0,0,0,0,0,1,1,2,0,0,1);
    localparam logic [18:0] E_HALT    = ev(0,0,0,0,0,0,0,0,0,0,1,0,0);
    localparam logic [18:0] E_HALT_IL = ev(0,0,0,0,0,0,0,0,0,0,1,1,0);

    // Called just after a rising edge: drive, expect, compare at the falling edge, then advance the counter model.
    task automatic step(input logic [5:0] op, input logic rn, input logic [18:0] exp, input string tag);
        bus.codop = op;
        rst_n = rn;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        check(tag_q.pop_front(), 32'(obs()), 32'(exp_q.pop_front()));
        @(posedge clk);
        n_ret = !rn ? 0 : n_ret + int'(exp[0]);
        n_cyc = !rn ? 0 : n_cyc + int'(!exp[2]);
        #1;
    endtask

    task automatic check_counters(input string tag);
`ifdef CTRL_PERF_CNT_EN
        check({tag, "_cyc"}, bus.cycle_cnt, 32'(n_cyc));
        check({tag, "_ret"}, bus.instret_cnt, 32'(n_ret));
`else
        check({tag, "_cyc"}, bus.cycle_cnt, 32'd0);
        check({tag, "_ret"}, bus.instret_cnt, 32'd0);
`endif
    endtask

    initial begin
        bus.codop = 6'h00;
        #1;
        for (int i = 0; i < 3; i++) step(OPC_ADD, 1'b0, E_ZERO, "reset");
        check_counters("rst");
        for (int i = 0; i < 5; i++) begin
            step(G, 1'b1, E_FETCH, "r_fetch");
            step(OPC_ADD + 6'(i), 1'b1, E_DECODE, "r_decode");
            step(G, 1'b1, ev(0,0,0,0,i,1,0,0,0,0,0,0,0), "r_exec");
            step(G, 1'b1, E_WB_R, "r_wb");
        end
        step(G, 1'b1, E_FETCH, "addi_fetch");
        step(OPC_ADDI, 1'b1, E_DECODE, "addi_decode");
        step(G, 1'b1, E_ADDR, "addi_exec");
        step(G, 1'b1, E_WB_I, "addi_wb");
        step(G, 1'b1, E_FETCH, "lw_fetch");
        step(OPC_LW, 1'b1, E_DECODE, "lw_decode");
        step(G, 1'b1, E_ADDR, "lw_addr");
        step(G, 1'b1, E_MEM_RD, "lw_rd");
        step(G, 1'b1, E_MEM_WB, "lw_wb");
        step(G, 1'b1, E_FETCH, "sw_fetch");
        step(OPC_SW, 1'b1, E_DECODE, "sw_decode");
        step(G, 1'b1, E_ADDR, "sw_addr");
        step(G, 1'b1, E_MEM_WR, "sw_wr");
        step(G, 1'b1, E_FETCH, "beq_fetch");
        step(OPC_BEQ, 1'b1, E_DECODE, "beq_decode");
        step(G, 1'b1, E_BRANCH, "beq_branch");
        step(G, 1'b1, E_FETCH, "j_fetch");
        step(OPC_J, 1'b1, E_DECODE, "j_decode");
        step(G, 1'b1, E_JUMP, "j_jump");
        step(G, 1'b1, E_FETCH, "jal_fetch");
        step(OPC_JAL, 1'b1, E_DECODE, "jal_decode");
        step(G, 1'b1, E_JAL_LNK, "jal_link");
        step(G, 1'b1, E_JAL_WB, "jal_wb");
        check_counters("run");
        step(G, 1'b1, E_FETCH, "ill_fetch");
        step(6'h3E, 1'b1, E_DECODE, "ill_decode");
        for (int i = 0; i < 20; i++) step(OPC_ADD, 1'b1, E_HALT_IL, "ill_halt");
        check_counters("halt");
        step(OPC_ADD, 1'b0, E_ZERO, "ill_reset");
        step(G, 1'b1, E_FETCH, "ill_refetch");
        step(OPC_HALT, 1'b1, E_DECODE, "halt_decode");
        for (int i = 0; i < 3; i++) step(OPC_ADD, 1'b1, E_HALT, "halt_halt");
        step(OPC_ADD, 1'b0, E_ZERO, "halt_reset");
        step(G, 1'b1, E_FETCH, "swr_fetch");
        step(OPC_SW, 1'b1, E_DECODE, "swr_decode");
        step(G, 1'b1, E_ADDR, "swr_addr");
        step(G, 1'b0, E_ZERO, "swr_reset");
        check_counters("swr");
        step(G, 1'b1, E_FETCH, "swr_refetch");
        step(OPC_J, 1'b1, E_DECODE, "swr_decode2");
        step(G, 1'b1, E_JUMP, "swr_jump");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
